apb_master_arb: RTL and testbench

APB_MASTER_ARB -- requirements
Module: apb_master_arb

---
 rtl/apb_master_arb_pkg.sv | 25 ++
 rtl/apb_defines.svh | 13 +
 rtl/apb_rr_arb.sv | 43 ++++
 rtl/apb_master_arb.sv | 122 ++++++++++++
 tb/tb_apb_master_arb.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/apb_master_arb_pkg.sv
// ---------------------------------------------------------------------------
// apb_master_arb_pkg: shared types and state constants for apb_master_arb. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`include "apb_defines.svh"

package apb_master_arb_pkg;

  localparam int ADDR_W  = `ADDR_WIDTH;
  localparam int DATA_W  = `DATA_WIDTH;
  localparam int NUM_REQ = 2;

  localparam logic [1:0] ST_IDLE   = `APB_ST_IDLE;
  localparam logic [1:0] ST_SETUP  = `APB_ST_SETUP;
  localparam logic [1:0] ST_ACCESS = `APB_ST_ACCESS;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
  } req_slot_t;

endpackage

`default_nettype wire

// File: rtl/apb_defines.svh
// apb_defines: shared bus widths and APB master FSM state encodings. Rev 1.0
`ifndef APB_DEFINES_SVH
`define APB_DEFINES_SVH

`define ADDR_WIDTH 32
`define DATA_WIDTH 32

// APB defines block
`define APB_ST_IDLE   2'd0
`define APB_ST_SETUP  2'd1
`define APB_ST_ACCESS 2'd2

`endif

// File: rtl/apb_rr_arb.sv
// ---------------------------------------------------------------------------
// apb_rr_arb: 2-way round-robin arbiter with a last-grant pointer. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module apb_rr_arb (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [1:0] req_i,
  input  logic       advance_i,
  output logic [1:0] winner_o
);

  // Index of the requester served last; reset to 1 so requester 0 wins first tie.
  logic last_q, last_d;

  always_comb begin
    case (req_i)
      2'b01:   winner_o = 2'b01;
      2'b10:   winner_o = 2'b10;
      2'b11:   winner_o = last_q ? 2'b01 : 2'b10;
      default: winner_o = 2'b00;
    endcase
  end

  always_comb begin
    last_d = last_q;
    if (advance_i && (winner_o != 2'b00)) begin
      last_d = winner_o[1];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/apb_master_arb.sv
// ---------------------------------------------------------------------------
// apb_master_arb: two-requester APB master, round-robin arbitrated, no wait states. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`include "apb_defines.svh"

module apb_master_arb
  import apb_master_arb_pkg::*;
#(
  parameter int SEL_WIDTH = 2,
  parameter int SEL_LSB   = 12
) (
  input  logic                      pclk,
  input  logic                      reset,
  input  logic [1:0]                req,
  input  logic [1:0]                req_write,
  input  logic [`ADDR_WIDTH-1:0]    req_addr0,
  input  logic [`ADDR_WIDTH-1:0]    req_addr1,
  input  logic [`DATA_WIDTH-1:0]    req_wdata0,
  input  logic [`DATA_WIDTH-1:0]    req_wdata1,
  output logic [1:0]                gnt,
  output logic [1:0]                done,
  output logic [`DATA_WIDTH-1:0]    rdata,
  output logic [(2**SEL_WIDTH)-1:0] psel,
  output logic                      penable,
  output logic                      pwrite,
  output logic [`ADDR_WIDTH-1:0]    paddr,
  output logic [`DATA_WIDTH-1:0]    pwdata,
  input  logic [`DATA_WIDTH-1:0]    prdata
);

  localparam int NUM_SLV = 2**SEL_WIDTH;

  logic [1:0]             state_q, state_d;
  logic [1:0]             winner;
  logic                   enter_setup;
  req_slot_t              slot;
  logic [1:0]             gnt_q;
  logic [1:0]             done_q;
  logic [1:0]             owner_q;
  logic [`ADDR_WIDTH-1:0] paddr_q;
  logic [`DATA_WIDTH-1:0] pwdata_q;
  logic                   pwrite_q;
  logic [`DATA_WIDTH-1:0] rdata_q;

  // A new transfer can start from IDLE or directly out of ACCESS.
  assign enter_setup = (|req) && ((state_q == ST_IDLE) || (state_q == ST_ACCESS));

  apb_rr_arb u_arb (
    .clk_i     (pclk),
    .rst_ni    (reset),
    .req_i     (req),
    .advance_i (enter_setup),
    .winner_o  (winner)
  );

  always_comb begin
    if (winner[1]) begin
      slot.addr  = req_addr1;
      slot.wdata = req_wdata1;
      slot.write = req_write[1];
    end else begin
      slot.addr  = req_addr0;
      slot.wdata = req_wdata0;
      slot.write = req_write[0];
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = (|req) ? ST_SETUP : ST_IDLE;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: state_d = (|req) ? ST_SETUP : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      gnt_q    <= 2'b00;
      done_q   <= 2'b00;
      owner_q  <= 2'b00;
      paddr_q  <= '0;
      pwdata_q <= '0;
      pwrite_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= enter_setup ? winner : 2'b00;
      if (enter_setup) begin
        paddr_q  <= slot.addr;
        pwdata_q <= slot.wdata;
        pwrite_q <= slot.write;
        owner_q  <= winner;
      end
      done_q <= (state_q == ST_ACCESS) ? owner_q : 2'b00;
      if ((state_q == ST_ACCESS) && !pwrite_q) begin
        rdata_q <= prdata;
      end
    end
  end

  always_comb begin
    psel = '0;
    if (state_q != ST_IDLE) begin
      psel = NUM_SLV'(1) << paddr_q[SEL_LSB +: SEL_WIDTH];
    end
  end

  assign penable = (state_q == ST_ACCESS);
  assign gnt     = gnt_q;
  assign done    = done_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;
  assign pwrite  = pwrite_q;
  assign rdata   = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arb.sv
// ---------------------------------------------------------------------------
// tb_apb_master_arb: self-checking bench against a transaction-level model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_apb_master_arb;
  import apb_master_arb_pkg::*;

  localparam int SEL_WIDTH = 2;
  localparam int SEL_LSB   = 12;

  logic              pclk = 1'b0;
  logic              reset;
  logic [1:0]        req, req_write;
  logic [ADDR_W-1:0] req_addr0, req_addr1, paddr;
  logic [DATA_W-1:0] req_wdata0, req_wdata1, rdata, pwdata, prdata;
  logic [1:0]        gnt, done;
  logic [3:0]        psel;
  logic              penable, pwrite;

  apb_master_arb #(.SEL_WIDTH(SEL_WIDTH), .SEL_LSB(SEL_LSB)) dut (
    .pclk(pclk), .reset(reset), .req(req), .req_write(req_write),
    .req_addr0(req_addr0), .req_addr1(req_addr1),
    .req_wdata0(req_wdata0), .req_wdata1(req_wdata1),
    .gnt(gnt), .done(done), .rdata(rdata),
    .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata)
  );

  always #5 pclk = ~pclk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              write;
    logic [DATA_W-1:0] prd;
  } xfer_t;

  xfer_t             q0[$], q1[$];
  int                n_vec = 0, n_err = 0;
  logic              m_last;   // requester served last (1 => requester 0 wins a tie)
  logic [DATA_W-1:0] m_rdata;
  logic [7:0]        gnt_log;

  function automatic xfer_t rand_xfer();
    xfer_t x;
    x.addr  = ADDR_W'($urandom);
    x.wdata = DATA_W'($urandom);
    x.write = 1'($urandom);
    x.prd   = DATA_W'($urandom);
    return x;
  endfunction

  function automatic logic [3:0] exp_psel(input logic [ADDR_W-1:0] a);
    logic [1:0] s;
    s = a[SEL_LSB +: SEL_WIDTH];
    return 4'(1) << s;
  endfunction

  // Requesters hold req while they still have queued transfers.
  task automatic drive_reqs();
    req = {q1.size() > 0, q0.size() > 0};
    if (q0.size() > 0) begin
      req_addr0 = q0[0].addr; req_wdata0 = q0[0].wdata; req_write[0] = q0[0].write;
    end
    if (q1.size() > 0) begin
      req_addr1 = q1[0].addr; req_wdata1 = q1[0].wdata; req_write[1] = q1[0].write;
    end
  endtask

  // Plays out all queued transfers starting from IDLE and checks every phase.
  task automatic run_burst();
    int         total;
    int         w;
    xfer_t      cur;
    logic [1:0] prev_done;
    logic [1:0] exp_gnt;
    total     = q0.size() + q1.size();
    prev_done = 2'b00;
    drive_reqs();
    for (int k = 0; k < total; k++) begin
      if ((q0.size() > 0) && (q1.size() > 0)) w = m_last ? 0 : 1;
      else w = (q0.size() > 0) ? 0 : 1;
      cur     = (w == 0) ? q0.pop_front() : q1.pop_front();
      m_last  = w[0];
      exp_gnt = 2'(1) << w;
      @(posedge pclk); #1;
      n_vec++;
      if ({gnt, penable, psel, done} !== {exp_gnt, 1'b0, exp_psel(cur.addr), prev_done}) begin
        n_err++;
        $display("FAIL setup_ctrl xfer %0d: gnt/pen/psel/done got %b/%b/%b/%b want %b/%b/%b/%b",
                 k, gnt, penable, psel, done, exp_gnt, 1'b0, exp_psel(cur.addr), prev_done);
      end
      n_vec++;
      if ({paddr, pwdata, pwrite, rdata} !== {cur.addr, cur.wdata, cur.write, m_rdata}) begin
        n_err++;
        $display("FAIL setup_data xfer %0d: addr/wdata/write/rdata got %h/%h/%b/%h want %h/%h/%b/%h",
                 k, paddr, pwdata, pwrite, rdata, cur.addr, cur.wdata, cur.write, m_rdata);
      end
      gnt_log = {gnt_log[5:0], gnt};
      drive_reqs();
      prdata = DATA_W'($urandom);
      @(posedge pclk); #1;
      n_vec++;
      if ({gnt, penable, psel, done, paddr, pwdata, pwrite, rdata} !==
          {2'b00, 1'b1, exp_psel(cur.addr), 2'b00, cur.addr, cur.wdata, cur.write, m_rdata}) begin
        n_err++;
        $display("FAIL access xfer %0d: gnt/pen/psel/done/addr/write/rdata got %b/%b/%b/%b/%h/%b/%h want 00/1/%b/00/%h/%b/%h",
                 k, gnt, penable, psel, done, paddr, pwrite, rdata,
                 exp_psel(cur.addr), cur.addr, cur.write, m_rdata);
      end
      prdata = cur.prd;
      if (!cur.write) m_rdata = cur.prd;
      prev_done = exp_gnt;
    end
    @(posedge pclk); #1;
    n_vec++;
    if ({done, gnt, penable, psel, rdata} !== {prev_done, 2'b00, 1'b0, 4'b0000, m_rdata}) begin
      n_err++;
      $display("FAIL completion: done/gnt/pen/psel/rdata got %b/%b/%b/%b/%h want %b/00/0/0000/%h",
               done, gnt, penable, psel, rdata, prev_done, m_rdata);
    end
    prdata = DATA_W'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b0; req = 2'b00; req_write = 2'b11; prdata = DATA_W'($urandom);
    req_addr0 = '1; req_addr1 = '1; req_wdata0 = '1; req_wdata1 = '1;
    repeat (2) @(posedge pclk);
    #1;
    n_vec++;
    if ({gnt, done, rdata, psel, penable, pwrite, paddr, pwdata} !== '0) begin
      n_err++;
      $display("FAIL reset_state: gnt/done/psel/pen/pwrite got %b/%b/%b/%b/%b paddr %h pwdata %h rdata %h want all zero",
               gnt, done, psel, penable, pwrite, paddr, pwdata, rdata);
    end
    m_last = 1'b1; m_rdata = '0;
    reset = 1'b1;
  endtask

  task automatic test_contention();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(rand_xfer());
      q1.push_back(rand_xfer());
    end
    gnt_log = '0;
    run_burst();
    n_vec++;
    if (gnt_log !== 8'b01_10_01_10) begin
      n_err++;
      $display("FAIL contention_order: gnt sequence got %b want 01100110", gnt_log);
    end
  endtask

  task automatic test_single_write();
    xfer_t x;
    x = rand_xfer();
    x.addr = 32'h0000_2004; x.wdata = 32'hA5A5_0001; x.write = 1'b1;
    q0.push_back(x);
    run_burst();
  endtask

  task automatic test_single_read();
    xfer_t x;
    x = rand_xfer();
    x.addr = 32'h0000_3000; x.write = 1'b0; x.prd = 32'hDEAD_BEEF;
    q1.push_back(x);
    run_burst();
    n_vec++;
    if (rdata !== 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL single_read: rdata got %h want deadbeef", rdata);
    end
  endtask

  task automatic test_write_after_read();
    xfer_t x;
    x = rand_xfer(); x.write = 1'b0; x.prd = 32'h1234_5678;
    q0.push_back(x);
    run_burst();
    x = rand_xfer(); x.write = 1'b1;
    q1.push_back(x);
    run_burst();
    n_vec++;
    if (rdata !== 32'h1234_5678) begin
      n_err++;
      $display("FAIL write_after_read: rdata got %h want 12345678", rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    xfer_t x;
    x = rand_xfer(); x.write = 1'b0;
    q0.push_back(x);
    drive_reqs();
    @(posedge pclk); #1;
    void'(q0.pop_front());
    drive_reqs();
    @(posedge pclk); #1;
    prdata = x.prd;
    reset  = 1'b0;
    @(posedge pclk); #1;
    n_vec++;
    if ({psel, penable, done, gnt, pwrite, paddr, pwdata, rdata} !== '0) begin
      n_err++;
      $display("FAIL reset_mid_access: psel/pen/done/gnt/pwrite got %b/%b/%b/%b/%b paddr %h rdata %h want all zero",
               psel, penable, done, gnt, pwrite, paddr, rdata);
    end
    reset = 1'b1; m_last = 1'b1; m_rdata = '0;
    @(posedge pclk); #1;
    n_vec++;
    if ({done, psel, penable} !== 7'b0) begin
      n_err++;
      $display("FAIL reset_no_done: done/psel/pen got %b/%b/%b want 00/0000/0", done, psel, penable);
    end
    q1.push_back(rand_xfer());
    run_burst();
  endtask

  task automatic test_random();
    int n0, n1;
    for (int b = 0; b < 10; b++) begin
      n0 = $urandom_range(0, 3);
      n1 = $urandom_range(0, 3);
      if ((n0 + n1) == 0) n0 = 1;
      for (int i = 0; i < n0; i++) q0.push_back(rand_xfer());
      for (int i = 0; i < n1; i++) q1.push_back(rand_xfer());
      run_burst();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_contention();
    test_single_write();
    test_single_read();
    test_write_after_read();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
